systolic_west_feeder: RTL and testbench
=======================================

# systolic_west_feeder

Upstream feeder for the systolic array's west edge. It accepts activation vectors (one element per array row) over a valid/ready handshake and buffers them in a small FIFO. It then drives them into the west inputs of the first `mac_unit` column with the diagonal skew the array needs: row r is delayed r cycles. It also flushes the skew after the last vector of a matrix, generates the shared `mac_matrix_counter`, and pulses `done` when the final element has entered the array.

## Interface
- `DATA_SIZE`, 8, element width; matches the `mac_unit` data size.
- `ROWS`, 4, number of array rows fed (≥1).
- `FIFO_DEPTH`, 4, input buffer depth in vectors (power of two, ≥2).

- `clock` in 1: single clock, all state on rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `in_data` in ROWS*DATA_SIZE: activation vector; row r = bits [r*DATA_SIZE +: DATA_SIZE], unsigned.
- `in_valid` in 1: `in_data`/`in_last` valid.
- `in_last` in 1: vector is the final one of the current matrix.
- `in_ready` out 1: FIFO not full (combinational from occupancy).
- `west_data` out ROWS*2*DATA_SIZE: row r = bits [r*2*DATA_SIZE +: 2*DATA_SIZE], drives `data_west1_in` of row r.
- `west_valid` out ROWS: per-row element valid, skewed with `west_data`.
- `mac_matrix_counter` out 32: cycles since current matrix started streaming.
- `busy` out 1: state ≠ IDLE.
- `done` out 1: one-cycle pulse; the last element has reached the west edge of every row.

## Operation
- **FIFO:** entries are {last, data}.
  - Push when `in_valid && in_ready`.
  - `in_ready = (count != FIFO_DEPTH)`.
  - No bypass: a pushed entry is poppable the next cycle.
  - Push and pop in the same cycle are legal; count is unchanged.
  - Pushes are accepted in every state, including DRAIN, DONE and IDLE.
- **FSM** states: IDLE, STREAM, DRAIN, DONE.
  - IDLE: go to STREAM when the FIFO is non-empty; clear `mac_matrix_counter` on that edge.
  - STREAM: pop one entry every cycle the FIFO is non-empty. Stage-0 input = popped data, valid=1. If the FIFO is empty, stage-0 input = 0 with valid=0 (bubble), and the FSM stays in STREAM.
  - STREAM, popped entry has last=1: go to DRAIN with drain count ROWS-1. If ROWS==1, go to DONE instead.
  - DRAIN: stage-0 input = 0 with valid=0, no pops. After exactly ROWS-1 cycles, go to DONE.
  - DONE: `done`=1 for one cycle, then go to IDLE.
- **Skew pipeline:** row r is a shift register of r+1 registers; the last register drives `west_data`/`west_valid` row r.
  - An element popped in cycle t appears on row r in cycle t+1+r.
  - Output = zero-extended: upper DATA_SIZE bits are always 0.
  - Invalid slots drive 0 data with valid=0.
- **`mac_matrix_counter`:**
  - +1 at every edge where state is STREAM or DRAIN.
  - Holds in DONE and IDLE.
  - Wraps modulo 2^32.
- **`busy`** = state ≠ IDLE.
- **Reset**, at any time including mid-matrix:
  - state=IDLE, FIFO emptied.
  - All pipeline registers, `west_data`, `west_valid`, `mac_matrix_counter`, `done` = 0.
  - `busy`=0, `in_ready`=1.
  - The partial matrix is discarded and no `done` is issued.

## Timing
- Push to first pop: ≥2 cycles (FIFO write, then the IDLE→STREAM edge).
- Pop of the last vector in cycle t:
  - its row-ROWS-1 element is visible in cycle t+ROWS;
  - `done` is high in cycle t+ROWS (same cycle);
  - IDLE at t+ROWS+1.
- A matrix of N vectors with no bubbles: `mac_matrix_counter` = N+ROWS-1 during DONE.
- Each bubble in STREAM adds 1 to both the `done` latency and the counter.
- DONE→IDLE→STREAM: a queued next matrix starts one cycle after DONE (one IDLE cycle).
- Throughput: one vector per cycle while the FIFO is non-empty.

## Test plan
- **Reset:** assert `reset` asynchronously mid-cycle.
  - All outputs 0 immediately, `in_ready`=1, `busy`=0.
  - Release; with no input, outputs stay 0.
- **Single vector, ROWS=4:** push `in_data`=0x44332211 with `in_last`=1.
  - Pop at t. Row0 = 0x0011 at t+1, row1 = 0x0022 at t+2, row2 = 0x0033 at t+3, row3 = 0x0044 at t+4.
  - `done`=1 only at t+4, with counter=4.
- **Three back-to-back vectors** A=0x04030201, B=0x08070605, C=0x0C0B0A09 (last on C).
  - Row0 shows 01,05,09 at t+1..t+3; row3 shows 04,08,0C at t+4..t+6.
  - `done` at t+6, counter=6.
- **Bubble:** push A, skip one cycle, then push B with `in_last`.
  - Every row has one valid=0, data=0 slot between A and B.
  - `done` arrives 1 cycle later than the back-to-back case, counter=N+ROWS.
- **FIFO full:** during DRAIN of a matrix, hold `in_valid`=1 with five distinct vectors.
  - Exactly 4 accepted; `in_ready`=0 from the 4th acceptance until the first pop in STREAM.
  - The 5th vector is accepted after that, with no loss or reordering.
- **Reset mid-DRAIN:** assert `reset` one cycle after the last pop.
  - No `done` pulse; all `west_valid`=0.
  - A subsequent single-vector matrix behaves exactly as the single-vector scenario.

Source files
------------

// File: rtl/systolic_west_feeder_if.sv
// Handshake and west-edge bundle between the activation source, the feeder and the array.
// The feeder sits on the slave side; the producer/observer uses the master side.
interface systolic_west_feeder_if #(
    parameter int unsigned DATA_SIZE = 8,
    parameter int unsigned ROWS      = 4
);
    logic [ROWS*DATA_SIZE-1:0]   in_data;
    logic                        in_valid;
    logic                        in_last;
    logic                        in_ready;
    logic [ROWS*2*DATA_SIZE-1:0] west_data;
    logic [ROWS-1:0]             west_valid;
    logic [31:0]                 mac_matrix_counter;
    logic                        busy;
    logic                        done;

    modport slave (
        input  in_data, in_valid, in_last,
        output in_ready, west_data, west_valid, mac_matrix_counter, busy, done
    );

    modport master (
        output in_data, in_valid, in_last,
        input  in_ready, west_data, west_valid, mac_matrix_counter, busy, done
    );
endinterface

// File: rtl/systolic_west_feeder.sv
// Buffers activation vectors in a small FIFO and streams them into the array's west edge
// with a per-row diagonal skew (row r delayed r cycles), flushing the skew after each matrix.
module systolic_west_feeder #(
    parameter int unsigned DATA_SIZE  = 8,
    parameter int unsigned ROWS       = 4,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input logic                   clock,
    input logic                   reset,
    systolic_west_feeder_if.slave bus_io
);
    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = $clog2(ROWS + 1);
    localparam int unsigned VW = ROWS * DATA_SIZE;
    localparam logic [AW:0] Full = (AW + 1)'(FIFO_DEPTH);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StStream = 2'd1;
    localparam logic [1:0] StDrain  = 2'd2;
    localparam logic [1:0] StDone   = 2'd3;

    // FIFO entry layout: {last, data}
    logic [VW:0]     mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [AW:0]     count_q;
    logic            push, pop;
    logic [VW-1:0]   head_data;
    logic            head_last;

    logic [1:0]      state_q, state_d;
    logic [CW-1:0]   drain_q, drain_d;
    logic [31:0]     cnt_q, cnt_d;

    logic [ROWS*2*DATA_SIZE-1:0] west_data;
    logic [ROWS-1:0]             west_valid;

    assign bus_io.in_ready = (count_q != Full);
    assign push            = bus_io.in_valid && bus_io.in_ready;
    assign pop             = (state_q == StStream) && (count_q != '0);
    assign {head_last, head_data} = mem_q[rd_ptr_q];

    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {bus_io.in_last, bus_io.in_data};
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            if (push && !pop) begin
                count_q <= count_q + (AW + 1)'(1);
            end else if (!push && pop) begin
                count_q <= count_q - (AW + 1)'(1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (count_q != '0) begin
                    state_d = StStream;
                    cnt_d   = '0;
                end
            end
            StStream: begin
                cnt_d = cnt_q + 32'd1;
                if (pop && head_last) begin
                    if (ROWS == 1) begin
                        state_d = StDone;
                    end else begin
                        state_d = StDrain;
                        drain_d = CW'(ROWS - 1);
                    end
                end
            end
            StDrain: begin
                cnt_d   = cnt_q + 32'd1;
                drain_d = drain_q - CW'(1);
                if (drain_q == CW'(1)) state_d = StDone;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            drain_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            cnt_q   <= cnt_d;
        end
    end

    // Row r is a chain of r+1 registers; bubbles and flush slots shift in as zero.
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        logic [DATA_SIZE-1:0] data_q [r+1];
        logic [r:0]           valid_q;

        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                for (int k = 0; k <= r; k++) data_q[k] <= '0;
                valid_q <= '0;
            end else begin
                data_q[0]  <= pop ? head_data[r*DATA_SIZE +: DATA_SIZE] : '0;
                valid_q[0] <= pop;
                for (int k = 1; k <= r; k++) begin
                    data_q[k]  <= data_q[k-1];
                    valid_q[k] <= valid_q[k-1];
                end
            end
        end

        assign west_data[r*2*DATA_SIZE +: 2*DATA_SIZE] = {{DATA_SIZE{1'b0}}, data_q[r]};
        assign west_valid[r]                           = valid_q[r];
    end

    assign bus_io.west_data          = west_data;
    assign bus_io.west_valid         = west_valid;
    assign bus_io.mac_matrix_counter = cnt_q;
    assign bus_io.busy               = (state_q != StIdle);
    assign bus_io.done               = (state_q == StDone);
endmodule

// File: tb/tb_systolic_west_feeder.sv
// Scoreboard bench for systolic_west_feeder: stimulus queues expected per-row elements and
// done events; a negedge monitor pops and compares whatever the west edge presents.
module tb_systolic_west_feeder;
    localparam int unsigned DW   = 8;
    localparam int unsigned ROWS = 4;
    localparam int unsigned FD   = 4;

    typedef struct packed {
        logic [31:0] cnt;
        int          at;
    } done_exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;
    int   n_vec = 0;
    int   n_err = 0;

    logic [15:0] exp_q [ROWS][$];
    done_exp_t   done_q[$];

    systolic_west_feeder_if #(.DATA_SIZE(DW), .ROWS(ROWS)) bus ();

    systolic_west_feeder #(
        .DATA_SIZE (DW),
        .ROWS      (ROWS),
        .FIFO_DEPTH(FD)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus_io(bus)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s", name);
    endtask

    // Monitor: every valid slot must match the next queued element of its row.
    always @(negedge clock) begin
        logic [15:0] got;
        done_exp_t   de;
        if (!reset) begin
            for (int r = 0; r < ROWS; r++) begin
                got = bus.west_data[r*16 +: 16];
                if (bus.west_valid[r]) begin
                    if (exp_q[r].size() == 0) begin
                        flag($sformatf("row%0d_unexpected_valid data=%0h cyc=%0d", r, got, cyc));
                    end else begin
                        check($sformatf("row%0d_data", r), got, exp_q[r].pop_front());
                    end
                end else if (got != 16'h0) begin
                    check($sformatf("row%0d_idle_zero", r), got, 64'h0);
                end
            end
            if (bus.done) begin
                if (done_q.size() == 0) begin
                    flag($sformatf("unexpected_done cyc=%0d", cyc));
                end else begin
                    de = done_q.pop_front();
                    check("done_counter", bus.mac_matrix_counter, de.cnt);
                    check("done_cycle", cyc, de.at);
                end
            end
        end
    end

    task automatic push_vec(input logic [31:0] d, input logic last,
                            output int acc_cyc, output int stalls);
        int guard;
        guard  = 0;
        stalls = 0;
        @(negedge clock);
        bus.in_data  = d;
        bus.in_last  = last;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && guard < 100) begin
            stalls++;
            guard++;
            @(negedge clock);
        end
        if (!bus.in_ready) begin
            flag("push_timeout");
            bus.in_valid = 1'b0;
            acc_cyc      = cyc;
        end else begin
            @(posedge clock);
            #1;
            acc_cyc      = cyc;
            bus.in_valid = 1'b0;
            bus.in_last  = 1'b0;
            for (int r = 0; r < ROWS; r++) exp_q[r].push_back({8'h00, d[r*8 +: 8]});
        end
    endtask

    task automatic expect_done(input logic [31:0] cnt, input int at);
        done_exp_t de;
        de.cnt = cnt;
        de.at  = at;
        done_q.push_back(de);
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while ((done_q.size() != 0 || exp_q[0].size() != 0 || exp_q[ROWS-1].size() != 0)
               && guard < 200) begin
            guard++;
            @(negedge clock);
        end
        if (guard >= 200) flag("drain_timeout");
        repeat (3) @(negedge clock);
        check("idle_busy", bus.busy, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_west_valid"}, bus.west_valid, '0);
        check({tag, "_west_data"}, bus.west_data, '0);
        check({tag, "_counter"}, bus.mac_matrix_counter, '0);
        check({tag, "_busy"}, bus.busy, 1'b0);
        check({tag, "_done"}, bus.done, 1'b0);
        check({tag, "_in_ready"}, bus.in_ready, 1'b1);
    endtask

    initial begin
        int a0, a1, s0, s1, s2, s3, s4, tmp;
        bus.in_data  = '0;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;

        repeat (2) @(negedge clock);
        check_reset_outputs("por");
        reset = 1'b0;
        repeat (3) @(negedge clock);
        check("quiet_valid", bus.west_valid, '0);
        check("quiet_busy", bus.busy, 1'b0);

        // Single vector: pop one cycle after push, done four cycles after pop.
        push_vec(32'h44332211, 1'b1, a0, s0);
        expect_done(32'd4, a0 + 5);
        wait_idle();

        // Three back-to-back vectors.
        push_vec(32'h04030201, 1'b0, a0, s0);
        push_vec(32'h08070605, 1'b0, tmp, s0);
        push_vec(32'h0C0B0A09, 1'b1, tmp, s0);
        expect_done(32'd6, a0 + 7);
        wait_idle();

        // One bubble in STREAM between A and B.
        push_vec(32'h14131211, 1'b0, a0, s0);
        repeat (2) @(negedge clock);
        push_vec(32'h28272625, 1'b1, tmp, s0);
        expect_done(32'd6, a0 + 7);
        wait_idle();

        // FIFO fills during DRAIN of a single-vector matrix; fifth push stalls 2 cycles.
        push_vec(32'hA4A3A2A1, 1'b1, a0, s0);
        expect_done(32'd4, a0 + 5);
        repeat (2) @(negedge clock);
        check("drain_busy", bus.busy, 1'b1);
        push_vec(32'h31302F2E, 1'b0, a1, s0);
        push_vec(32'h41403F3E, 1'b0, tmp, s1);
        push_vec(32'h51504F4E, 1'b0, tmp, s2);
        push_vec(32'h61605F5E, 1'b0, tmp, s3);
        push_vec(32'h71706F6E, 1'b1, tmp, s4);
        expect_done(32'd8, a1 + 12);
        check("full_stalls_1to4", s0 + s1 + s2 + s3, 0);
        check("full_stall_5th", s4, 2);
        wait_idle();

        // Asynchronous reset one cycle after the last pop.
        push_vec(32'h88776655, 1'b1, a0, s0);
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b1;
        for (int r = 0; r < ROWS; r++) exp_q[r].delete();
        done_q.delete();
        #1;
        check_reset_outputs("async");
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        repeat (8) @(negedge clock);
        check("post_reset_busy", bus.busy, 1'b0);

        push_vec(32'h44332211, 1'b1, a0, s0);
        expect_done(32'd4, a0 + 5);
        wait_idle();

        for (int r = 0; r < ROWS; r++) check($sformatf("row%0d_leftover", r), exp_q[r].size(), 0);
        check("done_leftover", done_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end
endmodule
